// File: rtl/picorv32_trace_pkg.sv
// Shared constants for the picorv32 trace capture block: register map,
// CTRL/STATUS bit positions and the trace word width.
package picorv32_trace_pkg;

    localparam int TRACE_W = 36;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DATA_LO = 2'd2,
        REG_DATA_HI = 2'd3
    } reg_idx_e;

    localparam int CTRL_ENABLE       = 0;
    localparam int CTRL_STOP_ON_TRAP = 1;
    localparam int CTRL_CLEAR        = 2;
    localparam int CTRL_WRAP         = 3;
    localparam int CTRL_IRQ_EN       = 4;

    localparam int ST_RUNNING   = 0;
    localparam int ST_TRAP_STOP = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_EMPTY     = 3;
    localparam int ST_FULL      = 4;

endpackage

// File: rtl/picorv32_trace_ram.sv
// Simple dual-port trace buffer: one write port, one synchronous read port
// with a registered output, written so it maps onto block RAM.
module picorv32_trace_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/picorv32_trace_capture.sv
// Captures the picorv32 trace stream into a circular buffer, optionally
// freezing on a trap, and exposes it through a Wishbone classic slave.
module picorv32_trace_capture
    import picorv32_trace_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trace_valid_i,
    input  logic [TRACE_W-1:0] trace_data_i,
    input  logic               trap_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [1:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               irq_o
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic enable_reg, enable_next, stop_on_trap_reg, stop_on_trap_next;
    logic wrap_reg, wrap_next, irq_en_reg, irq_en_next;
    logic overflow_reg, overflow_next, trap_stop_reg, trap_stop_next;
    logic hold_valid_reg, hold_valid_next, trap_q_reg;
    logic [3:0]  hold_reg, hold_next;
    logic pend_reg, pop_ok_reg, ack_reg, ack_next, irq_reg;
    logic [31:0] dat_reg, dat_next;

    logic [TRACE_W-1:0] ram_q;
    logic req, req_pop, wr_ctrl, clr, full, empty, push, pop_hit, pop;
    logic overwrite, drop, ram_we, push_grow, trap_fire;
    logic unused_bits;

    assign unused_bits = &{1'b0, wb_dat_i[31:5], wb_sel_i[3:1]};

    // Requests are masked while ack is high and during the DATA_LO wait state,
    // so a held strobe never issues a second pop before its ack.
    assign req     = wb_cyc_i & wb_stb_i & ~ack_reg & ~pend_reg;
    assign req_pop = req & ~wb_we_i & (wb_adr_i == REG_DATA_LO);
    assign wr_ctrl = req & wb_we_i & wb_sel_i[0] & (wb_adr_i == REG_CTRL);
    assign clr     = wr_ctrl & wb_dat_i[CTRL_CLEAR];

    assign full      = (count_reg == DEPTH);
    assign empty     = (count_reg == '0);
    assign push      = enable_reg & trace_valid_i;
    assign pop_hit   = pend_reg & pop_ok_reg & ~empty;
    assign pop       = pop_hit & ~clr;
    // A pop completing on the same edge frees a slot, so a full buffer then
    // accepts the push without overwriting.
    assign overwrite = push & full & ~pop & wrap_reg;
    assign drop      = push & full & ~pop & ~wrap_reg;
    assign ram_we    = push & ~drop & ~clr;
    assign push_grow = ram_we & ~overwrite;
    assign trap_fire = trap_i & ~trap_q_reg & enable_reg & stop_on_trap_reg;

    picorv32_trace_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (TRACE_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (trace_data_i),
        .re    (req_pop),
        .raddr (rd_ptr_reg),
        .rdata (ram_q)
    );

    always_comb begin
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        count_next        = count_reg;
        overflow_next     = overflow_reg;
        trap_stop_next    = trap_stop_reg;
        hold_next         = hold_reg;
        hold_valid_next   = hold_valid_reg;
        enable_next       = enable_reg;
        stop_on_trap_next = stop_on_trap_reg;
        wrap_next         = wrap_reg;
        irq_en_next       = irq_en_reg;

        if (clr) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            count_next      = '0;
            overflow_next   = 1'b0;
            trap_stop_next  = 1'b0;
            hold_valid_next = 1'b0;
        end else begin
            if (ram_we)
                wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(1);
            if (pop | overwrite)
                rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(1);
            if (push_grow & ~pop)
                count_next = count_reg + CNT_W'(1);
            else if (pop & ~push_grow)
                count_next = count_reg - CNT_W'(1);
            if (overwrite | drop)
                overflow_next = 1'b1;
            if (trap_fire)
                trap_stop_next = 1'b1;
            if (pend_reg) begin
                hold_valid_next = pop_hit;
                hold_next       = pop_hit ? ram_q[TRACE_W-1:32] : 4'h0;
            end
        end

        if (wr_ctrl) begin
            enable_next       = wb_dat_i[CTRL_ENABLE];
            stop_on_trap_next = wb_dat_i[CTRL_STOP_ON_TRAP];
            wrap_next         = wb_dat_i[CTRL_WRAP];
            irq_en_next       = wb_dat_i[CTRL_IRQ_EN];
        end
        if (trap_fire)
            enable_next = 1'b0;
    end

    always_comb begin
        ack_next = (req & ~req_pop) | pend_reg;
        dat_next = dat_reg;
        if (pend_reg) begin
            dat_next = pop_hit ? ram_q[31:0] : 32'h0;
        end else if (req & ~wb_we_i) begin
            case (wb_adr_i)
                REG_CTRL:    dat_next = {27'h0, irq_en_reg, wrap_reg, 1'b0,
                                         stop_on_trap_reg, enable_reg};
                REG_STATUS:  dat_next = {16'(count_reg), 11'h0, full, empty,
                                         overflow_reg, trap_stop_reg, enable_reg};
                REG_DATA_HI: dat_next = {hold_valid_reg, 27'h0, hold_reg};
                default:     dat_next = dat_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            enable_reg       <= 1'b0;
            stop_on_trap_reg <= 1'b0;
            wrap_reg         <= 1'b0;
            irq_en_reg       <= 1'b0;
            overflow_reg     <= 1'b0;
            trap_stop_reg    <= 1'b0;
            hold_reg         <= 4'h0;
            hold_valid_reg   <= 1'b0;
            trap_q_reg       <= 1'b0;
            pend_reg         <= 1'b0;
            pop_ok_reg       <= 1'b0;
            ack_reg          <= 1'b0;
            dat_reg          <= 32'h0;
            irq_reg          <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            enable_reg       <= enable_next;
            stop_on_trap_reg <= stop_on_trap_next;
            wrap_reg         <= wrap_next;
            irq_en_reg       <= irq_en_next;
            overflow_reg     <= overflow_next;
            trap_stop_reg    <= trap_stop_next;
            hold_reg         <= hold_next;
            hold_valid_reg   <= hold_valid_next;
            trap_q_reg       <= trap_i;
            pend_reg         <= req_pop;
            pop_ok_reg       <= ~empty;
            ack_reg          <= ack_next;
            dat_reg          <= dat_next;
            irq_reg          <= trap_stop_reg & irq_en_reg;
        end
    end

    assign wb_dat_o = dat_reg;
    assign wb_ack_o = ack_reg;
    assign irq_o    = irq_reg;

endmodule

// File: tb/tb_picorv32_trace_capture.sv
// Directed bench for picorv32_trace_capture built with a 4-entry buffer;
// each task drives one scenario and compares against hand-computed values.
module tb_picorv32_trace_capture;

    localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_LO = 2'd2, A_HI = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_valid = 1'b0;
    logic [35:0] trace_data = '0;
    logic        trap = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_o;
    logic        ack_o, irq;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    picorv32_trace_capture #(.DEPTH_LOG2(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .trace_valid_i (trace_valid),
        .trace_data_i  (trace_data),
        .trap_i        (trap),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_adr_i      (adr),
        .wb_dat_i      (wdat),
        .wb_sel_i      (sel),
        .wb_dat_o      (dat_o),
        .wb_ack_o      (ack_o),
        .irq_o         (irq)
    );

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0; rd = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack_o) begin
                lat = i;
                rd  = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_cmp++;
        if (lat == 0) begin
            n_mis++;
            $display("FAIL wb_ack_timeout adr=%0d got=no_ack exp=ack_within_8", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, a, d, 4'hF, rd, lat);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] rd, output int lat);
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd, lat);
    endtask

    task automatic push(input logic [35:0] d);
        trace_valid = 1'b1; trace_data = d;
        @(posedge clk); #1;
        trace_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack_o, irq, dat_o} !== 34'h0) begin
            n_mis++;
            $display("FAIL reset_outputs got ack=%b irq=%b dat=%h exp=0/0/0", ack_o, irq, dat_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0000_0008) begin n_mis++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h8); end
        n_cmp++;
        if (lat !== 1) begin n_mis++; $display("FAIL reg_latency got=%0d exp=1", lat); end
        wb_read(A_CTRL, rd, lat);
        n_cmp++;
        if (rd !== 32'h0) begin n_mis++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
        wb_read(A_HI, rd, lat);
        n_cmp++;
        if (rd !== 32'h0) begin n_mis++; $display("FAIL reset_data_hi got=%h exp=0", rd); end
    endtask

    task automatic test_basic_capture();
        logic [31:0] rd;
        int lat;
        logic [31:0] exp_lo [3] = '{32'h10, 32'h20, 32'h30};
        logic [31:0] exp_hi [3] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
        wb_write(A_CTRL, 32'h01);
        push(36'h1_0000_0010);
        push(36'h2_0000_0020);
        push(36'h3_0000_0030);
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0003_0001) begin n_mis++; $display("FAIL basic_status got=%h exp=%h", rd, 32'h0003_0001); end
        for (int i = 0; i < 3; i++) begin
            wb_read(A_LO, rd, lat);
            n_cmp++;
            if (rd !== exp_lo[i]) begin n_mis++; $display("FAIL basic_lo[%0d] got=%h exp=%h", i, rd, exp_lo[i]); end
            n_cmp++;
            if (lat !== 2) begin n_mis++; $display("FAIL pop_latency got=%0d exp=2", lat); end
            wb_read(A_HI, rd, lat);
            n_cmp++;
            if (rd !== exp_hi[i]) begin n_mis++; $display("FAIL basic_hi[%0d] got=%h exp=%h", i, rd, exp_hi[i]); end
        end
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0000_0009) begin n_mis++; $display("FAIL basic_status_end got=%h exp=%h", rd, 32'h9); end
    endtask

    task automatic test_full(input logic wrap, input logic [31:0] first);
        logic [31:0] rd;
        int lat;
        wb_write(A_CTRL, 32'h04);
        wb_write(A_CTRL, wrap ? 32'h09 : 32'h01);
        for (int i = 0; i < 6; i++) push(36'(i));
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0004_0015) begin n_mis++; $display("FAIL full_status wrap=%b got=%h exp=%h", wrap, rd, 32'h0004_0015); end
        for (int i = 0; i < 4; i++) begin
            wb_read(A_LO, rd, lat);
            n_cmp++;
            if (rd !== first + 32'(i)) begin
                n_mis++; $display("FAIL full_pop wrap=%b [%0d] got=%h exp=%h", wrap, i, rd, first + 32'(i));
            end
        end
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0000_000D) begin n_mis++; $display("FAIL full_status_end wrap=%b got=%h exp=%h", wrap, rd, 32'hD); end
    endtask

    task automatic test_empty_pop();
        logic [31:0] rd;
        int lat;
        wb_read(A_HI, rd, lat);
        n_cmp++;
        if (rd !== 32'h8000_0000) begin n_mis++; $display("FAIL hold_before_empty got=%h exp=%h", rd, 32'h8000_0000); end
        wb_read(A_LO, rd, lat);
        n_cmp++;
        if (rd !== 32'h0 || lat !== 2) begin n_mis++; $display("FAIL empty_lo got=%h/%0d exp=0/2", rd, lat); end
        wb_read(A_HI, rd, lat);
        n_cmp++;
        if (rd !== 32'h0) begin n_mis++; $display("FAIL empty_hi got=%h exp=0", rd); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] rd;
        int lat;
        wb_write(A_CTRL, 32'h04);
        wb_write(A_CTRL, 32'h01);
        for (int i = 0; i < 4; i++) push(36'h0_0000_00A0 + 36'(i));
        // pop request now; push lands on the edge the pop completes
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_LO;
        @(posedge clk); #1;
        trace_valid = 1'b1; trace_data = 36'h0_0000_00A4;
        @(posedge clk); #1;
        trace_valid = 1'b0;
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'hA0) begin
            n_mis++; $display("FAIL pushpop_ack got=%b/%h exp=1/%h", ack_o, dat_o, 32'hA0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0004_0011) begin n_mis++; $display("FAIL pushpop_status got=%h exp=%h", rd, 32'h0004_0011); end
        for (int i = 1; i <= 4; i++) begin
            wb_read(A_LO, rd, lat);
            n_cmp++;
            if (rd !== 32'hA0 + 32'(i)) begin n_mis++; $display("FAIL pushpop_pop[%0d] got=%h exp=%h", i, rd, 32'hA0 + 32'(i)); end
        end
    endtask

    task automatic test_trap_stop();
        logic [31:0] rd;
        int lat;
        wb_write(A_CTRL, 32'h04);
        wb_write(A_CTRL, 32'h13);
        push(36'h5_0000_0051);
        push(36'h6_0000_0062);
        trap = 1'b1;
        push(36'h0_0000_0007);
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL irq_early got=%b exp=0", irq); end
        push(36'h0_0000_0008);
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL irq_late got=%b exp=1", irq); end
        push(36'h0_0000_0009);
        trap = 1'b0;
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0003_0002) begin n_mis++; $display("FAIL trap_status got=%h exp=%h", rd, 32'h0003_0002); end
        wb_read(A_CTRL, rd, lat);
        n_cmp++;
        if (rd !== 32'h12) begin n_mis++; $display("FAIL trap_ctrl got=%h exp=%h", rd, 32'h12); end
        wb_read(A_LO, rd, lat);
        wb_read(A_HI, rd, lat);
        n_cmp++;
        if (rd !== 32'h8000_0005) begin n_mis++; $display("FAIL trap_hi0 got=%h exp=%h", rd, 32'h8000_0005); end
        wb_read(A_LO, rd, lat);
        wb_read(A_LO, rd, lat);
        n_cmp++;
        if (rd !== 32'h7) begin n_mis++; $display("FAIL trap_word got=%h exp=7", rd); end
    endtask

    task automatic test_clear();
        logic [31:0] rd;
        int lat;
        wb_write(A_CTRL, 32'h01);
        push(36'h0_0000_00C1);
        push(36'h0_0000_00C2);
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0002_0003) begin n_mis++; $display("FAIL clear_pre_status got=%h exp=%h", rd, 32'h0002_0003); end
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; wdat = 32'h05; sel = 4'hF;
        trace_valid = 1'b1; trace_data = 36'h0_0000_00C3;
        @(posedge clk); #1;
        trace_valid = 1'b0;
        n_cmp++;
        if (ack_o !== 1'b1) begin n_mis++; $display("FAIL clear_ack got=%b exp=1", ack_o); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0000_0009) begin n_mis++; $display("FAIL clear_status got=%h exp=%h", rd, 32'h9); end
        begin
            logic [31:0] dummy;
            wb_xfer(1'b1, A_CTRL, 32'h00, 4'hE, dummy, lat);
        end
        wb_read(A_CTRL, rd, lat);
        n_cmp++;
        if (rd !== 32'h01) begin n_mis++; $display("FAIL ctrl_sel0 got=%h exp=1", rd); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd;
        int lat;
        push(36'h0_0000_00D1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_LO;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ack_o !== 1'b0 || dat_o !== 32'h0) begin
            n_mis++; $display("FAIL rst_mid_read got ack=%b dat=%h exp=0/0", ack_o, dat_o);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(A_STATUS, rd, lat);
        n_cmp++;
        if (rd !== 32'h0000_0008) begin n_mis++; $display("FAIL rst_status got=%h exp=%h", rd, 32'h8); end
        wb_read(A_CTRL, rd, lat);
        n_cmp++;
        if (rd !== 32'h0) begin n_mis++; $display("FAIL rst_ctrl got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_full(1'b0, 32'd0);
        test_full(1'b1, 32'd2);
        test_empty_pop();
        test_push_pop_full();
        test_trap_stop();
        test_clear();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
